// File: rtl/dcnn_pkg.sv
// Shared types and default geometry for the DCNN load sequencer.
package dcnn_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_IMG = 2'd1,
        LOAD_CNN = 2'd2,
        FINISH   = 2'd3
    } state_t;

    localparam int unsigned DEF_ROW_W  = 480;
    localparam int unsigned DEF_N_ROWS = 29;
    localparam int unsigned DEF_WORD_W = 16;

endpackage

// File: rtl/dcnn_edge_detect.sv
// Registers the host send strobe and flags its rising edge in the current cycle.
module dcnn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_q;

endmodule

// File: rtl/dcnn_load_sequencer.sv
// Two-phase DCNN load: N_ROWS image rows on send edges, then CNN words until word_last.
// Optional watchdog enabled by defining DCNN_LOAD_TIMEOUT_EN (adds parameter TIMEOUT).
module dcnn_load_sequencer
    import dcnn_pkg::*;
#(
    parameter int unsigned ROW_W     = DEF_ROW_W,
    parameter int unsigned N_ROWS    = DEF_N_ROWS,
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned RADDR_W   = 5
`ifdef DCNN_LOAD_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               send,
    input  logic               stop,
    input  logic [ROW_W-1:0]   host_row,
    input  logic               word_valid,
    input  logic [WORD_W-1:0]  host_word,
    input  logic               word_last,
    output logic               row_we,
    output logic [RADDR_W-1:0] row_addr,
    output logic [ROW_W-1:0]   row_out,
    output logic               cnn_we,
    output logic [ADDR_W-1:0]  cnn_addr,
    output logic [WORD_W-1:0]  cnn_word,
    output logic               load_process,
    output logic               cnn_image,
    output logic               done,
    output logic               err
);

    state_t r_state;
    state_t w_next;

    logic [RADDR_W-1:0] r_row_cnt;
    logic [ADDR_W-1:0]  r_cnn_cnt;

    logic w_send_rise;
    logic w_row_acc;
    logic w_word_acc;
    logic w_last_row;
    logic w_full;
    logic w_timeout;

    logic w_row_we;
    logic w_cnn_we;
    logic w_done;
    logic w_load_process;
    logic w_cnn_image;
    logic w_err;

    dcnn_edge_detect u_send_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (send),
        .o_rise (w_send_rise)
    );

    assign w_row_acc  = (r_state == LOAD_IMG) && w_send_rise && !stop;
    assign w_word_acc = (r_state == LOAD_CNN) && word_valid && !stop;
    assign w_last_row = (r_row_cnt == RADDR_W'(N_ROWS - 1));
    assign w_full     = (r_cnn_cnt == ADDR_W'(MAX_WORDS - 1));

`ifdef DCNN_LOAD_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        w_loading;

    assign w_loading = (r_state == LOAD_IMG) || (r_state == LOAD_CNN);
    // Stop-held cycles count as stalls; any acceptance restarts the count.
    assign w_timeout = w_loading && !w_row_acc && !w_word_acc && (r_wdog == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst || !w_loading || w_row_acc || w_word_acc || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = LOAD_IMG;
            end
            LOAD_IMG: begin
                if (w_timeout)                    w_next = IDLE;
                else if (w_row_acc && w_last_row) w_next = LOAD_CNN;
            end
            LOAD_CNN: begin
                if (w_timeout)                                w_next = IDLE;
                else if (w_word_acc && (word_last || w_full)) w_next = FINISH;
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_row_we       = 1'b0;
        w_cnn_we       = 1'b0;
        w_done         = 1'b0;
        w_load_process = load_process;
        w_cnn_image    = cnn_image;
        w_err          = err;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load_process = 1'b1;
                    w_err          = 1'b0;
                end
            end
            LOAD_IMG: begin
                if (w_row_acc) begin
                    w_row_we = 1'b1;
                    if (w_last_row) w_cnn_image = 1'b1;
                end
            end
            LOAD_CNN: begin
                if (w_word_acc) begin
                    w_cnn_we = 1'b1;
                    if (w_full && !word_last) w_err = 1'b1;
                end
            end
            FINISH: begin
                w_done         = 1'b1;
                w_load_process = 1'b0;
                w_cnn_image    = 1'b0;
            end
            default: begin
                w_load_process = 1'b0;
                w_cnn_image    = 1'b0;
            end
        endcase
        if (w_timeout) begin
            w_load_process = 1'b0;
            w_cnn_image    = 1'b0;
            w_err          = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_we       <= 1'b0;
            row_addr     <= '0;
            row_out      <= '0;
            cnn_we       <= 1'b0;
            cnn_addr     <= '0;
            cnn_word     <= '0;
            load_process <= 1'b0;
            cnn_image    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            r_row_cnt    <= '0;
            r_cnn_cnt    <= '0;
        end else begin
            row_we       <= w_row_we;
            cnn_we       <= w_cnn_we;
            done         <= w_done;
            load_process <= w_load_process;
            cnn_image    <= w_cnn_image;
            err          <= w_err;
            if ((r_state == IDLE) && start) begin
                r_row_cnt <= '0;
                r_cnn_cnt <= '0;
            end
            if (w_row_we) begin
                row_addr  <= r_row_cnt;
                row_out   <= host_row;
                r_row_cnt <= r_row_cnt + RADDR_W'(1);
            end
            if (w_cnn_we) begin
                cnn_addr  <= r_cnn_cnt;
                cnn_word  <= host_word;
                r_cnn_cnt <= r_cnn_cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dcnn_load_sequencer.sv
// Directed self-checking bench for dcnn_load_sequencer (main instance plus a MAX_WORDS=8 instance).
module tb_dcnn_load_sequencer;

    localparam int unsigned ROW_W  = 480;
    localparam int unsigned WORD_W = 16;

    logic clk = 1'b0;
    logic rst, start, start8, send, stop, word_valid, word_last;
    logic [ROW_W-1:0]  host_row;
    logic [WORD_W-1:0] host_word;

    logic              row_we, cnn_we, load_process, cnn_image, done, err;
    logic [4:0]        row_addr;
    logic [ROW_W-1:0]  row_out;
    logic [11:0]       cnn_addr;
    logic [WORD_W-1:0] cnn_word;

    logic              row_we8, cnn_we8, load_process8, cnn_image8, done8, err8;
    logic [4:0]        row_addr8;
    logic [ROW_W-1:0]  row_out8;
    logic [2:0]        cnn_addr8;
    logic [WORD_W-1:0] cnn_word8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcnn_load_sequencer #(
        .ROW_W(480), .N_ROWS(29), .WORD_W(16), .MAX_WORDS(4096), .ADDR_W(12), .RADDR_W(5)
`ifdef DCNN_LOAD_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .send(send), .stop(stop),
        .host_row(host_row), .word_valid(word_valid), .host_word(host_word),
        .word_last(word_last), .row_we(row_we), .row_addr(row_addr), .row_out(row_out),
        .cnn_we(cnn_we), .cnn_addr(cnn_addr), .cnn_word(cnn_word),
        .load_process(load_process), .cnn_image(cnn_image), .done(done), .err(err)
    );

    dcnn_load_sequencer #(
        .ROW_W(480), .N_ROWS(29), .WORD_W(16), .MAX_WORDS(8), .ADDR_W(3), .RADDR_W(5)
    ) dut8 (
        .clk(clk), .rst(rst), .start(start8), .send(send), .stop(stop),
        .host_row(host_row), .word_valid(word_valid), .host_word(host_word),
        .word_last(word_last), .row_we(row_we8), .row_addr(row_addr8), .row_out(row_out8),
        .cnn_we(cnn_we8), .cnn_addr(cnn_addr8), .cnn_word(cnn_word8),
        .load_process(load_process8), .cnn_image(cnn_image8), .done(done8), .err(err8)
    );

    function automatic logic [ROW_W-1:0] make_row(input int r);
        logic [31:0] w;
        w = 32'hC0DE0000 | 32'(r);
        return {15{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rows with no checking, used to reach the CNN phase.
    task automatic drive_rows();
        for (int r = 0; r < 29; r++) begin
            send = 1'b1; host_row = make_row(r);
            tick();
            send = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({row_we, cnn_we, load_process, cnn_image, done, err} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags got %b exp 000000", {row_we, cnn_we, load_process, cnn_image, done, err});
        end
        n_checks++;
        if (row_addr !== 5'd0 || cnn_addr !== 12'd0 || cnn_word !== 16'd0 || row_out !== '0) begin
            n_errors++;
            $display("FAIL reset_data got ra=%0h ca=%0h cw=%0h exp all 0", row_addr, cnn_addr, cnn_word);
        end
        tick();
        n_checks++;
        if (load_process !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_no_start got load_process=%b exp 0", load_process);
        end
    endtask

    task automatic test_rows();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (load_process !== 1'b1 || cnn_image !== 1'b0) begin
            n_errors++;
            $display("FAIL start_flags got lp=%b ci=%b exp lp=1 ci=0", load_process, cnn_image);
        end
        for (int r = 0; r < 29; r++) begin
            if (r == 5) begin
                stop = 1'b1; send = 1'b1; host_row = make_row(99);
                tick();
                n_checks++;
                if (row_we !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stop_drop_we got %b exp 0", row_we);
                end
                stop = 1'b0;
                tick();
                n_checks++;
                if (row_we !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stop_held_we got %b exp 0", row_we);
                end
                send = 1'b0;
                tick();
            end
            send = 1'b1; host_row = make_row(r);
            tick();
            send = 1'b0;
            n_checks++;
            if (row_we !== 1'b1 || row_addr !== 5'(r)) begin
                n_errors++;
                $display("FAIL row_write[%0d] got we=%b addr=%0d exp we=1 addr=%0d", r, row_we, row_addr, r);
            end
            n_checks++;
            if (row_out !== make_row(r)) begin
                n_errors++;
                $display("FAIL row_data[%0d] got %h exp %h", r, row_out[31:0], make_row(r) & 480'hFFFFFFFF);
            end
            n_checks++;
            if (cnn_image !== (r == 28)) begin
                n_errors++;
                $display("FAIL cnn_image_row[%0d] got %b exp %b", r, cnn_image, (r == 28));
            end
            if (r == 10) start = 1'b1;
            tick();
            start = 1'b0;
            n_checks++;
            if (row_we !== 1'b0 || cnn_we !== 1'b0) begin
                n_errors++;
                $display("FAIL strobe_single[%0d] got row_we=%b cnn_we=%b exp 0 0", r, row_we, cnn_we);
            end
            tick();
        end
        n_checks++;
        if (load_process !== 1'b1 || cnn_image !== 1'b1) begin
            n_errors++;
            $display("FAIL cnn_phase_flags got lp=%b ci=%b exp 1 1", load_process, cnn_image);
        end
    endtask

    task automatic test_cnn_words();
        for (int i = 0; i < 10; i++) begin
            word_valid = 1'b1; host_word = 16'(i); word_last = (i == 9);
            tick();
            n_checks++;
            if (cnn_we !== 1'b1 || cnn_addr !== 12'(i) || cnn_word !== 16'(i) || row_we !== 1'b0) begin
                n_errors++;
                $display("FAIL cnn_write[%0d] got we=%b addr=%0d word=%0h row_we=%b exp 1 %0d %0h 0",
                         i, cnn_we, cnn_addr, cnn_word, row_we, i, i);
            end
            n_checks++;
            if (done !== 1'b0) begin
                n_errors++;
                $display("FAIL early_done[%0d] got %b exp 0", i, done);
            end
        end
        word_valid = 1'b0; word_last = 1'b0;
        tick();
        n_checks++;
        if (done !== 1'b1 || cnn_we !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse got done=%b cnn_we=%b exp 1 0", done, cnn_we);
        end
        n_checks++;
        if (load_process !== 1'b0 || cnn_image !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL finish_flags got lp=%b ci=%b err=%b exp 0 0 0", load_process, cnn_image, err);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL done_single got %b exp 0", done);
        end
    endtask

    task automatic test_overflow();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        drive_rows();
        n_checks++;
        if (cnn_image8 !== 1'b1 || load_process !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_phase got ci8=%b main_lp=%b exp 1 0", cnn_image8, load_process);
        end
        for (int i = 0; i < 9; i++) begin
            word_valid = 1'b1; host_word = 16'h0100 + 16'(i); word_last = 1'b0;
            tick();
            if (i < 8) begin
                n_checks++;
                if (cnn_we8 !== 1'b1 || cnn_addr8 !== 3'(i) || cnn_word8 !== 16'h0100 + 16'(i)) begin
                    n_errors++;
                    $display("FAIL ovf_write[%0d] got we=%b addr=%0d word=%0h exp 1 %0d %0h",
                             i, cnn_we8, cnn_addr8, cnn_word8, i, 16'h0100 + 16'(i));
                end
            end else begin
                n_checks++;
                if (cnn_we8 !== 1'b0 || done8 !== 1'b1 || err8 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ovf_end got we=%b done=%b err=%b exp 0 1 1", cnn_we8, done8, err8);
                end
            end
        end
        word_valid = 1'b0;
        tick();
        n_checks++;
        if (done8 !== 1'b0 || err8 !== 1'b1 || cnn_we8 !== 1'b0 || load_process8 !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_after got done=%b err=%b we=%b lp=%b exp 0 1 0 0", done8, err8, cnn_we8, load_process8);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_rows();
        for (int i = 0; i < 4; i++) begin
            word_valid = 1'b1; host_word = 16'hA000 + 16'(i); word_last = 1'b0;
            tick();
        end
        n_checks++;
        if (cnn_we !== 1'b1 || cnn_addr !== 12'd3) begin
            n_errors++;
            $display("FAIL mid_pre got we=%b addr=%0d exp 1 3", cnn_we, cnn_addr);
        end
        rst = 1'b1; word_last = 1'b1;
        tick();
        rst = 1'b0; word_valid = 1'b0; word_last = 1'b0;
        n_checks++;
        if ({row_we, cnn_we, load_process, cnn_image, done, err} !== 6'b0 ||
            cnn_addr !== 12'd0 || cnn_word !== 16'd0 || row_addr !== 5'd0) begin
            n_errors++;
            $display("FAIL mid_reset got flags=%b ca=%0d cw=%0h ra=%0d exp 0",
                     {row_we, cnn_we, load_process, cnn_image, done, err}, cnn_addr, cnn_word, row_addr);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || cnn_we !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_no_done[%0d] got done=%b we=%b exp 0 0", k, done, cnn_we);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        send = 1'b1; host_row = make_row(7);
        tick();
        send = 1'b0;
        n_checks++;
        if (row_we !== 1'b1 || row_addr !== 5'd0 || row_out !== make_row(7)) begin
            n_errors++;
            $display("FAIL restart_row got we=%b addr=%0d exp 1 0", row_we, row_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

`ifdef DCNN_LOAD_TIMEOUT_EN
    task automatic test_timeout();
        start = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        n_checks++;
        if (load_process !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL wdog_early got lp=%b err=%b exp 1 0", load_process, err);
        end
        tick();
        n_checks++;
        if (load_process !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL wdog_fire got lp=%b err=%b done=%b exp 0 1 0", load_process, err, done);
        end
        stop = 1'b0; send = 1'b1; host_row = make_row(3);
        tick();
        send = 1'b0;
        n_checks++;
        if (row_we !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL wdog_idle got row_we=%b done=%b err=%b exp 0 0 1", row_we, done, err);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; start8 = 1'b0; send = 1'b0; stop = 1'b0;
        host_row = '0; word_valid = 1'b0; host_word = '0; word_last = 1'b0;
        test_reset();
        test_rows();
        test_cnn_words();
        test_overflow();
        test_reset_mid();
`ifdef DCNN_LOAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
